// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the two-port memory arbiter
//
// Holds the arbiter state encoding, the requester index constants used by the
// round-robin pointer, and the default stall limit.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  // Requester indices, also the encoding of the "last granted" pointer.
  localparam logic M0 = 1'b0;  // instruction fetch
  localparam logic M1 = 1'b1;  // load/store

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and shared-memory signal bundle for mem_arbiter
//
// Signals:
//   i_m{0,1}_addr/data/wr_valid/rd_ready : requester -> arbiter
//   o_m{0,1}_wr_ready/data/rd_valid      : arbiter -> requester
//   o_addr/o_data/o_wr_valid/o_rd_ready  : arbiter -> memory
//   i_wr_ready/i_data/i_rd_valid         : memory -> arbiter
// Modports:
//   slave  : the arbiter side
//   master : the environment (requesters plus memory) side
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface mem_arbiter_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] i_m0_addr,     i_m1_addr;
  logic [DATA_WIDTH-1:0] i_m0_data,     i_m1_data;
  logic                  i_m0_wr_valid, i_m1_wr_valid;
  logic                  o_m0_wr_ready, o_m1_wr_ready;
  logic [DATA_WIDTH-1:0] o_m0_data,     o_m1_data;
  logic                  o_m0_rd_valid, o_m1_rd_valid;
  logic                  i_m0_rd_ready, i_m1_rd_ready;

  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_wr_valid;
  logic                  i_wr_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_rd_valid;
  logic                  o_rd_ready;

  modport slave (
    input  i_m0_addr, i_m1_addr, i_m0_data, i_m1_data,
    input  i_m0_wr_valid, i_m1_wr_valid, i_m0_rd_ready, i_m1_rd_ready,
    output o_m0_wr_ready, o_m1_wr_ready, o_m0_data, o_m1_data,
    output o_m0_rd_valid, o_m1_rd_valid,
    output o_addr, o_data, o_wr_valid, o_rd_ready,
    input  i_wr_ready, i_data, i_rd_valid
  );

  modport master (
    output i_m0_addr, i_m1_addr, i_m0_data, i_m1_data,
    output i_m0_wr_valid, i_m1_wr_valid, i_m0_rd_ready, i_m1_rd_ready,
    input  o_m0_wr_ready, o_m1_wr_ready, o_m0_data, o_m1_data,
    input  o_m0_rd_valid, o_m1_rd_valid,
    input  o_addr, o_data, o_wr_valid, o_rd_ready,
    output i_wr_ready, i_data, i_rd_valid
  );

endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
//
// Ports:
//   i_req[1:0]  : request vector (bit0 = m0, bit1 = m1)
//   i_last      : index of the requester granted most recently
//   o_grant[1:0]: one-hot pick, 0 when nobody requests
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      // Contention: favour whoever was not served last.
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter onto one memory port
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : requester and memory signals (mem_arbiter_if.slave)
//   o_grant[1:0]   : one-hot current owner, 0 when idle
//   o_timeout      : one-cycle pulse when a stalled transfer is aborted
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  mem_arbiter_if.slave     bus,
  output logic [1:0]       o_grant,
  output logic             o_timeout
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic                  req0, req1;
  logic [1:0]            pick;
  logic                  own0, own1;
  logic                  cur, cur_req, oth_req;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] data_mux;
  logic                  wr_valid_mux, rd_ready_mux;
  logic                  done;
  logic [CW-1:0]         cnt_inc;
  logic                  stall_abort;

  assign req0 = bus.i_m0_wr_valid | bus.i_m0_rd_ready;
  assign req1 = bus.i_m1_wr_valid | bus.i_m1_rd_ready;

  rr_pick2 u_pick (
    .i_req   ({req1, req0}),
    .i_last  (last_q),
    .o_grant (pick)
  );

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  // Owner's request mirrored onto the memory port; a write hides the read.
  always_comb begin
    addr_mux     = '0;
    data_mux     = '0;
    wr_valid_mux = 1'b0;
    rd_ready_mux = 1'b0;
    if (own0) begin
      addr_mux     = bus.i_m0_addr;
      data_mux     = bus.i_m0_data;
      wr_valid_mux = bus.i_m0_wr_valid;
      rd_ready_mux = bus.i_m0_rd_ready & ~bus.i_m0_wr_valid;
    end else if (own1) begin
      addr_mux     = bus.i_m1_addr;
      data_mux     = bus.i_m1_data;
      wr_valid_mux = bus.i_m1_wr_valid;
      rd_ready_mux = bus.i_m1_rd_ready & ~bus.i_m1_wr_valid;
    end
  end

  assign bus.o_addr        = addr_mux;
  assign bus.o_data        = data_mux;
  assign bus.o_wr_valid    = wr_valid_mux;
  assign bus.o_rd_ready    = rd_ready_mux;
  assign bus.o_m0_wr_ready = own0 & bus.i_wr_ready;
  assign bus.o_m1_wr_ready = own1 & bus.i_wr_ready;
  assign bus.o_m0_rd_valid = own0 & bus.i_rd_valid;
  assign bus.o_m1_rd_valid = own1 & bus.i_rd_valid;
  assign bus.o_m0_data     = bus.i_data;
  assign bus.o_m1_data     = bus.i_data;

  assign done = (wr_valid_mux & bus.i_wr_ready) | (rd_ready_mux & bus.i_rd_valid);

  assign cur     = own1;
  assign cur_req = cur ? req1 : req0;
  assign oth_req = cur ? req0 : req1;

  // Stall count including the current cycle; abort once it hits the limit.
  assign cnt_inc     = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
  assign stall_abort = (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          state_d = pick[0] ? OWN0 : OWN1;
          last_d  = pick[1];
          cnt_d   = '0;
        end
      end
      OWN0, OWN1: begin
        if (!cur_req) begin
          state_d = IDLE;
        end else if (done || stall_abort) begin
          timeout_d = ~done;
          // Hand straight over to the other side; the served one waits.
          if (oth_req) begin
            state_d = cur ? OWN0 : OWN1;
            last_d  = ~cur;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            cnt_d   = cnt_inc;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      last_q    <= M1;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_grant   = {own1, own0};
  assign o_timeout = timeout_q;

endmodule
